// File: rtl/spi_master_core.sv
// spi_master_core
//   SPI master engine. One transfer per start pulse: assert the selected chip
//   select, wait a lead delay, clock out N bits MSB first while capturing MISO,
//   wait a trail delay, release chip select, then hold all selects high for an
//   inter-frame gap before reporting done. Configuration and the transmit word
//   are latched at start, so the front end may change them while busy.
//
// Ports
//   CLK, RST        system clock (rising edge), asynchronous active-high reset
//   start_i         transfer request, honoured only when idle and cs_sel_i valid
//   cs_sel_i        chip-select index
//   spi_mode_i      {CPOL, CPHA}
//   sck_speed_i     SCK half-period H = 2 << sck_speed_i clocks
//   word_len_i      word length N = (word_len_i+1)*DATA_W/4 bits
//   IFG_i           inter-frame gap (clocks, 0 skips the gap)
//   CS_SCK_i        CS assert to first SCK edge (clocks, 0 treated as 1)
//   SCK_CS_i        trail hold before CS release (clocks, 0 treated as 1)
//   mosi_data_i     transmit word, right-justified
//   MISO_i          serial input
//   busy_o, done_o  transfer in progress / one-cycle completion pulse
//   miso_data_o     received word, right-justified, zero-extended
//   SCK_o, MOSI_o   serial clock and data out
//   CS_o            active-low chip selects
module spi_master_core #(
    parameter int DATA_W = 32,
    parameter int NUM_CS = 4,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic [CS_W-1:0]   cs_sel_i,
    input  logic [1:0]        spi_mode_i,
    input  logic [1:0]        sck_speed_i,
    input  logic [1:0]        word_len_i,
    input  logic [7:0]        IFG_i,
    input  logic [7:0]        CS_SCK_i,
    input  logic [7:0]        SCK_CS_i,
    input  logic [DATA_W-1:0] mosi_data_i,
    input  logic              MISO_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] miso_data_o,
    output logic              SCK_o,
    output logic              MOSI_o,
    output logic [NUM_CS-1:0] CS_o
);

    // Edge counter must reach 2*DATA_W.
    localparam int EW = $clog2(2 * DATA_W + 1);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

    state_t            state, state_nxt;

    // Latched per-transfer configuration
    logic              cpha;
    logic [1:0]        speed;
    logic [1:0]        wlen;
    logic [7:0]        ifg;
    logic [7:0]        cs_sck;
    logic [7:0]        sck_cs;

    logic [7:0]        cnt;      // cycles spent in LEAD / TRAIL / GAP
    logic [4:0]        hcnt;     // cycles within the current SCK half-period
    logic [EW-1:0]     ecnt;     // SCK edges issued so far
    logic [DATA_W-1:0] tx;       // left-aligned transmit shifter, next bit at MSB
    logic [DATA_W-1:0] rx;       // receive shifter, fills from bit 0

    logic              start_ok;
    logic [4:0]        half_len;
    logic [7:0]        lead_last;
    logic [7:0]        trail_last;
    logic [EW-1:0]     two_n;
    logic              lead_end;
    logic              half_end;
    logic              xfer_end;
    logic              trail_end;
    logic              gap_end;
    logic              sck_tick;
    logic              leading;
    int                shamt;
    logic [DATA_W-1:0] aligned;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        start_ok   = start_i && (int'(cs_sel_i) < NUM_CS);
        half_len   = 5'd2 << speed;
        lead_last  = (cs_sck == 8'd0) ? 8'd0 : cs_sck - 8'd1;
        trail_last = (sck_cs == 8'd0) ? 8'd0 : sck_cs - 8'd1;
        two_n      = EW'((int'(wlen) + 1) * (DATA_W / 2));

        lead_end   = (state == LEAD)  && (cnt == lead_last);
        half_end   = (hcnt == half_len - 5'd1);
        xfer_end   = (state == XFER)  && half_end && (ecnt == two_n);
        trail_end  = (state == TRAIL) && (cnt == trail_last);
        gap_end    = (state == GAP)   && (cnt == ifg - 8'd1);

        // SCK edges sit at the start of each half-period: the first one on
        // the LEAD->XFER boundary, the rest every H clocks. The final
        // half-period runs out with SCK back at CPOL and ends XFER.
        sck_tick   = lead_end || ((state == XFER) && half_end && (ecnt != two_n));
        leading    = ~ecnt[0];

        // Left-align the N-bit word so the serial bit is always the MSB.
        shamt      = (3 - int'(word_len_i)) * (DATA_W / 4);
        aligned    = mosi_data_i << shamt;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)  state_nxt = LEAD;
            LEAD:    if (lead_end)  state_nxt = XFER;
            XFER:    if (xfer_end)  state_nxt = TRAIL;
            TRAIL:   if (trail_end) state_nxt = (ifg == 8'd0) ? IDLE : GAP;
            GAP:     if (gap_end)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and pin outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            miso_data_o <= '0;
            SCK_o       <= 1'b0;
            MOSI_o      <= 1'b0;
            CS_o        <= '1;
            cpha        <= 1'b0;
            speed       <= 2'd0;
            wlen        <= 2'd0;
            ifg         <= 8'd0;
            cs_sck      <= 8'd0;
            sck_cs      <= 8'd0;
            cnt         <= 8'd0;
            hcnt        <= 5'd0;
            ecnt        <= '0;
            tx          <= '0;
            rx          <= '0;
        end else begin
            done_o <= 1'b0;

            case (state)
                IDLE: begin
                    SCK_o <= spi_mode_i[1];
                    if (start_ok) begin
                        busy_o <= 1'b1;
                        CS_o   <= ~(NUM_CS'(1) << cs_sel_i);
                        cpha   <= spi_mode_i[0];
                        speed  <= sck_speed_i;
                        wlen   <= word_len_i;
                        ifg    <= IFG_i;
                        cs_sck <= CS_SCK_i;
                        sck_cs <= SCK_CS_i;
                        cnt    <= 8'd0;
                        hcnt   <= 5'd0;
                        ecnt   <= '0;
                        rx     <= '0;
                        // CPHA=0 needs the first bit set up before the first
                        // (sampling) edge; CPHA=1 presents it on that edge.
                        if (!spi_mode_i[0]) begin
                            MOSI_o <= aligned[DATA_W-1];
                            tx     <= aligned << 1;
                        end else begin
                            tx     <= aligned;
                        end
                    end
                end
                LEAD: begin
                    cnt <= lead_end ? 8'd0 : cnt + 8'd1;
                end
                XFER: begin
                    hcnt <= half_end ? 5'd0 : hcnt + 5'd1;
                end
                TRAIL: begin
                    cnt <= cnt + 8'd1;
                    if (trail_end) begin
                        cnt         <= 8'd0;
                        CS_o        <= '1;
                        miso_data_o <= rx;
                        if (ifg == 8'd0) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    cnt <= cnt + 8'd1;
                    if (gap_end) begin
                        cnt    <= 8'd0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (sck_tick) begin
                SCK_o <= ~SCK_o;
                ecnt  <= ecnt + EW'(1);
                hcnt  <= 5'd0;
                if (leading) begin
                    if (!cpha) begin
                        rx <= {rx[DATA_W-2:0], MISO_i};
                    end else begin
                        MOSI_o <= tx[DATA_W-1];
                        tx     <= tx << 1;
                    end
                end else begin
                    if (cpha) begin
                        rx <= {rx[DATA_W-2:0], MISO_i};
                    end else if (ecnt != two_n - EW'(1)) begin
                        // no shift after the final trailing edge: MOSI keeps
                        // the last bit until the next transfer
                        MOSI_o <= tx[DATA_W-1];
                        tx     <= tx << 1;
                    end
                end
            end
        end
    end

endmodule
